// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_NOT  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_SRL  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SLA  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_ROL  = 4'b1000;
    localparam logic [3:0] OP_ADD  = 4'b1001;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_MULU = 4'b1100;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } alu_state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, signed or unsigned, one partial product per clock.
module mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic               active;

    // Most-negative operand negates to itself, which reads correctly as unsigned 2^(W-1).
    assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = active && (cnt == LAST);
    assign product  = neg ? -acc_next : acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            active <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            cnt    <= '0;
            neg    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            active <= 1'b1;
        end else if (active) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with valid/ready handshakes; single-cycle logic/arith ops plus iterative multiply.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic [2*WIDTH-1:0]   product,
    output logic                 of,
    output logic                 zero,
    output logic                 slt,
    output logic                 busy
);

    alu_state_t state_q, state_d;

    logic               accept;
    logic               is_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_of;
    logic               alu_slt;

    assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign is_mul    = (op == OP_MUL) || (op == OP_MULU);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == MUL);

    mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept && is_mul),
        .is_signed (op == OP_MUL),
        .a         (a),
        .b         (b),
        .done      (mul_done),
        .product   (mul_product)
    );

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        alu_slt = 1'b0;
        case (op)
            OP_NOT:  alu_res = ~a;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_SRL:  alu_res = {1'b0, a[WIDTH-1:1]};
            OP_SLL:  alu_res = {a[WIDTH-2:0], 1'b0};
            OP_SRA:  alu_res = {a[WIDTH-1], a[WIDTH-1:1]};
            OP_SLA:  alu_res = {a[WIDTH-1], a[WIDTH-3:0], 1'b0};
            OP_ROR:  alu_res = {a[0], a[WIDTH-1:1]};
            OP_ROL:  alu_res = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_ADD: begin
                alu_res = sum;
                alu_of  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_of  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                alu_slt = diff[WIDTH-1] ^ alu_of;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = is_mul ? MUL : DONE;
            MUL:  if (mul_done) state_d = DONE;
            DONE: begin
                if (accept) begin
                    state_d = is_mul ? MUL : DONE;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs only change on an accept or multiply completion, so they hold under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            result  <= '0;
            product <= '0;
            of      <= 1'b0;
            zero    <= 1'b0;
            slt     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && !is_mul) begin
                result  <= alu_res;
                product <= '0;
                of      <= alu_of;
                zero    <= (alu_res == '0) && !alu_of;
                slt     <= alu_slt;
            end else if (mul_done) begin
                result  <= '0;
                product <= mul_product;
                of      <= 1'b0;
                zero    <= (mul_product == '0);
                slt     <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the 8-bit combinational ALU. Width is set by `WIDTH`. Operands arrive over a valid/ready handshake, and results and flags leave registered over a second valid/ready handshake. Logic, shift, rotate, add and sub complete in one cycle. Signed and unsigned multiply run as an iterative shift-add over `WIDTH` cycles. It sits between the register-file read stage and writeback of the datapath.

## Interface
Reset is synchronous and active-low (`rst_n`), on a single clock `clk`.

Parameters:
- `WIDTH`, default 8: operand/result width. Legal range ≥ 4.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `in_valid` in 1: operand/op presented.
- `in_ready` out 1: block can accept; an accept occurs when `in_valid && in_ready`.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `op` in 4: opcode.
- `out_valid` out 1: result, product and flags are valid.
- `out_ready` in 1: consumer takes the result when `out_valid && out_ready`.
- `result` out WIDTH: ALU result; 0 for multiply ops.
- `product` out 2*WIDTH: multiply result; 0 for non-multiply ops.
- `of` out 1: signed overflow (ADD/SUB only).
- `zero` out 1: zero flag.
- `slt` out 1: signed less-than (SUB only).
- `busy` out 1: multiply in progress.

## Operation
Opcodes:
- 0000 NOT A.
- 0001 AND.
- 0010 OR.
- 0011 SRL A by 1.
- 0100 SLL A by 1.
- 0101 SRA A by 1.
- 0110 SLA: {a[W-1], a[W-3:0], 0}.
- 0111 ROR.
- 1000 ROL.
- 1001 ADD.
- 1010 SUB (A − B).
- 1011 MUL signed.
- 1100 MULU unsigned.
- 1101–1111: result = 0, product = 0, and all flags 0 except `zero` = 1.

Arithmetic:
- ADD/SUB are WIDTH-bit two's complement; the carry out is discarded.
- `of` = operand signs agree (B inverted for SUB) and result sign differs. `of` = 0 for all other ops.

Flags:
- `zero`: for non-multiply ops, `result == 0 && !of`. For multiply ops, `product == 0`.
- `slt`: for SUB only, `result[W-1] ^ of`, giving a correct signed compare even on overflow. 0 for all other ops.

MUL:
- Operands are converted to magnitudes. The most-negative value maps to 2^(W-1) and fits unsigned.
- W iterations of shift-add are performed.
- The product is negated if `a[W-1] ^ b[W-1]`.
- Full 2W-bit result; no overflow is possible. `of` = 0 and `slt` = 0.

MULU: same datapath with no sign conversion.

FSM states IDLE, MUL, DONE:
- IDLE → DONE on accepting a single-cycle op; outputs are registered on that edge.
- IDLE → MUL on accepting MUL/MULU; operands are latched and the iteration counter is cleared.
- MUL → DONE when the counter reaches W−1; the final sign fix is applied on that edge.
- DONE → IDLE when `out_ready`. If `in_valid` is also high in that cycle, the new op is accepted directly (back-to-back issue).

`in_ready` = (IDLE) || (DONE && `out_ready`), forced to 0 while `rst_n` = 0.

`busy` = state is MUL.

Output holding rule: while `out_valid && !out_ready`, the outputs `result`, `product`, `of`, `zero` and `slt` hold stable and no new op is accepted.

## Timing
- Reset values: `out_valid`, `result`, `product`, `of`, `zero`, `slt` and `busy` all 0; state IDLE; counter 0.
- Single-cycle ops: `out_valid` asserts on the edge after the accept (latency 1).
- MUL/MULU: `out_valid` asserts W+1 edges after the accept (latency 9 for W = 8). `busy` is high for the W cycles in between.
- Throughput: one single-cycle op per clock when `out_ready` is held high.
- Reset mid-multiply: the partial product is discarded. State is IDLE on the next edge and `out_valid` never asserts for the aborted op.
- `in_valid` held without an accept: operands are ignored. The block does not sample `a`, `b` or `op` except on an accept edge.

## Structure
- Package `alu_pkg`: opcode localparams (`OP_NOT` … `OP_MULU`) and state enum `alu_state_t` {IDLE, MUL, DONE}.
- Sub-module `mul_iter`: signed/unsigned iterative multiplier.
  - Inputs: start, is_signed, a, b.
  - Outputs: done, product.
  - Owns the counter and the accumulator.
- Single-cycle ops, flags, FSM and handshake live in `alu_seq`.

## Test plan
All scenarios use WIDTH = 8.
- ADD 0x7F + 0x01, `out_ready` = 1 → result 0x80, `of` = 1, `zero` = 0, `out_valid` one cycle after the accept.
- SUB 0x03 − 0x05 → result 0xFE, `of` = 0, `slt` = 1. SUB 0x80 − 0x01 → result 0x7F, `of` = 1, `slt` = 1, `zero` = 0.
- MUL 0xFD × 0x05 → product 0xFFF1, `busy` high 8 cycles, `out_valid` 9 cycles after the accept, `in_ready` low throughout. MUL 0x80 × 0x80 → 0x4000. MULU 0xFF × 0xFF → 0xFE01.
- SRA 0x81 → 0xC0. SLA 0x81 → 0x82. ROL 0x81 → 0x03. Opcode 1111 → result 0, `zero` = 1.
- Backpressure: `out_ready` = 0 for 3 cycles after the result with `in_valid` = 1 → outputs stable, no accept. On `out_ready` = 1 the next op is accepted that same cycle.
- Reset asserted on the 4th cycle of a MUL → all outputs 0 on the next edge, `in_ready` = 0 during reset. After release a new ADD 0x01 + 0x01 returns 0x02.
